// File: rtl/riscv_instr_decoder_if.sv
// Handshake/bus bundle for riscv_instr_decoder.
//   in_*      : instruction word source (valid/ready, word, PC)
//   out_*     : decoded result to consumer (valid/ready, decoded fields, PC)
//   *_cnt     : wrap-around counts of decoded and illegal words
// slave is the decoder view, master is the source/consumer view.
interface riscv_instr_decoder_if #(
    parameter int unsigned CNT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [31:0]      in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       out_name;
    logic [3:0]       out_format;
    logic [3:0]       out_category;
    logic [4:0]       out_rd;
    logic [4:0]       out_rs1;
    logic [4:0]       out_rs2;
    logic [31:0]      out_imm;
    logic             out_illegal;
    logic [31:0]      out_pc;
    logic [CNT_W-1:0] decoded_cnt;
    logic [CNT_W-1:0] illegal_cnt;

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_name, out_format, out_category,
               out_rd, out_rs1, out_rs2, out_imm, out_illegal, out_pc,
               decoded_cnt, illegal_cnt
    );

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_name, out_format, out_category,
               out_rd, out_rs1, out_rs2, out_imm, out_illegal, out_pc,
               decoded_cnt, illegal_cnt
    );
endinterface

// File: rtl/riscv_instr_decoder.sv
// Two-stage elastic RV32I instruction decoder.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous drop of all in-flight words
//   bus        : riscv_instr_decoder_if.slave (input word, decoded output, counters)
// S1 holds the raw word/PC, S2 holds the full decode; outputs come straight from S2.
module riscv_instr_decoder #(
    parameter int unsigned CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    riscv_instr_decoder_if.slave  bus
);
    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU, SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        NOP, FENCE, FENCEI, ECALL, EBREAK,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
    } name_e;

    typedef enum logic [3:0] {
        FMT_J, FMT_U, FMT_I, FMT_I_SHIFT, FMT_B, FMT_R, FMT_S
    } fmt_e;

    typedef enum logic [3:0] {
        CAT_LOAD, CAT_STORE, CAT_SHIFT, CAT_ARITH, CAT_LOGICAL, CAT_COMPARE,
        CAT_BRANCH, CAT_JUMP, CAT_SYNCH, CAT_SYSTEM, CAT_COUNTER, CAT_CSR
    } cat_e;

    typedef struct packed {
        name_e       name;
        fmt_e        fmt;
        cat_e        cat;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } dec_t;

    logic             r_s1_valid;
    logic [31:0]      r_s1_instr;
    logic [31:0]      r_s1_pc;
    logic             r_s2_valid;
    dec_t             r_s2_dec;
    logic [31:0]      r_s2_pc;
    logic [CNT_W-1:0] r_dec_cnt;
    logic [CNT_W-1:0] r_ill_cnt;

    logic             w_s1_adv;
    logic             w_s2_adv;
    logic [6:0]       w_op;
    logic [2:0]       w_f3;
    logic [6:0]       w_f7;
    name_e            w_name;
    fmt_e             w_fmt;
    cat_e             w_cat;
    logic             w_ok;
    logic             w_noregs;
    logic             w_csr;
    dec_t             w_dec;

    // Elastic pipeline control: a stage moves when it is empty or its successor moves.
    assign w_s2_adv    = !r_s2_valid || bus.out_ready;
    assign w_s1_adv    = !r_s1_valid || w_s2_adv;
    assign bus.in_ready = w_s1_adv;

    assign w_op = r_s1_instr[6:0];
    assign w_f3 = r_s1_instr[14:12];
    assign w_f7 = r_s1_instr[31:25];

    // Instruction class: name, format, category and legality from opcode/funct fields.
    always_comb begin
        w_ok     = 1'b1;
        w_name   = LUI;
        w_fmt    = FMT_I;
        w_cat    = CAT_ARITH;
        w_noregs = 1'b0;
        w_csr    = 1'b0;
        case (w_op)
            7'b0110111: begin w_name = LUI;   w_fmt = FMT_U; end
            7'b0010111: begin w_name = AUIPC; w_fmt = FMT_U; end
            7'b1101111: begin w_name = JAL;   w_fmt = FMT_J; w_cat = CAT_JUMP; end
            7'b1100111: begin
                w_name = JALR;
                w_cat  = CAT_JUMP;
                w_ok   = (w_f3 == 3'b000);
            end
            7'b1100011: begin
                w_fmt = FMT_B;
                w_cat = CAT_BRANCH;
                case (w_f3)
                    3'b000:  w_name = BEQ;
                    3'b001:  w_name = BNE;
                    3'b100:  w_name = BLT;
                    3'b101:  w_name = BGE;
                    3'b110:  w_name = BLTU;
                    3'b111:  w_name = BGEU;
                    default: w_ok   = 1'b0;
                endcase
            end
            7'b0000011: begin
                w_cat = CAT_LOAD;
                case (w_f3)
                    3'b000:  w_name = LB;
                    3'b001:  w_name = LH;
                    3'b010:  w_name = LW;
                    3'b100:  w_name = LBU;
                    3'b101:  w_name = LHU;
                    default: w_ok   = 1'b0;
                endcase
            end
            7'b0100011: begin
                w_fmt = FMT_S;
                w_cat = CAT_STORE;
                case (w_f3)
                    3'b000:  w_name = SB;
                    3'b001:  w_name = SH;
                    3'b010:  w_name = SW;
                    default: w_ok   = 1'b0;
                endcase
            end
            7'b0010011: begin
                case (w_f3)
                    // addi x0,x0,0 is reported as its own pseudo-instruction
                    3'b000: w_name = (r_s1_instr == 32'h0000_0013) ? NOP : ADDI;
                    3'b010: begin w_name = SLTI;  w_cat = CAT_COMPARE; end
                    3'b011: begin w_name = SLTIU; w_cat = CAT_COMPARE; end
                    3'b100: begin w_name = XORI;  w_cat = CAT_LOGICAL; end
                    3'b110: begin w_name = ORI;   w_cat = CAT_LOGICAL; end
                    3'b111: begin w_name = ANDI;  w_cat = CAT_LOGICAL; end
                    3'b001: begin
                        w_name = SLLI;
                        w_fmt  = FMT_I_SHIFT;
                        w_cat  = CAT_SHIFT;
                        w_ok   = (w_f7 == 7'b0000000);
                    end
                    default: begin
                        w_fmt = FMT_I_SHIFT;
                        w_cat = CAT_SHIFT;
                        if (w_f7 == 7'b0000000)      w_name = SRLI;
                        else if (w_f7 == 7'b0100000) w_name = SRAI;
                        else                         w_ok   = 1'b0;
                    end
                endcase
            end
            7'b0110011: begin
                w_fmt = FMT_R;
                if (w_f7 == 7'b0000000) begin
                    case (w_f3)
                        3'b000:  w_name = ADD;
                        3'b001:  begin w_name = SLL;  w_cat = CAT_SHIFT;   end
                        3'b010:  begin w_name = SLT;  w_cat = CAT_COMPARE; end
                        3'b011:  begin w_name = SLTU; w_cat = CAT_COMPARE; end
                        3'b100:  begin w_name = XOR;  w_cat = CAT_LOGICAL; end
                        3'b101:  begin w_name = SRL;  w_cat = CAT_SHIFT;   end
                        3'b110:  begin w_name = OR;   w_cat = CAT_LOGICAL; end
                        default: begin w_name = AND;  w_cat = CAT_LOGICAL; end
                    endcase
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b000) begin
                    w_name = SUB;
                end else if (w_f7 == 7'b0100000 && w_f3 == 3'b101) begin
                    w_name = SRA;
                    w_cat  = CAT_SHIFT;
                end else begin
                    w_ok = 1'b0;
                end
            end
            7'b0001111: begin
                w_cat    = CAT_SYNCH;
                w_noregs = 1'b1;
                case (w_f3)
                    3'b000:  w_name = FENCE;
                    3'b001:  w_name = FENCEI;
                    default: w_ok   = 1'b0;
                endcase
            end
            7'b1110011: begin
                if (w_f3 == 3'b000) begin
                    w_cat    = CAT_SYSTEM;
                    w_noregs = 1'b1;
                    if (r_s1_instr == 32'h0000_0073)      w_name = ECALL;
                    else if (r_s1_instr == 32'h0010_0073) w_name = EBREAK;
                    else                                  w_ok   = 1'b0;
                end else begin
                    w_cat = CAT_CSR;
                    w_csr = 1'b1;
                    case (w_f3)
                        3'b001:  w_name = CSRRW;
                        3'b010:  w_name = CSRRS;
                        3'b011:  w_name = CSRRC;
                        3'b101:  w_name = CSRRWI;
                        3'b110:  w_name = CSRRSI;
                        3'b111:  w_name = CSRRCI;
                        default: w_ok   = 1'b0;
                    endcase
                end
            end
            default: w_ok = 1'b0;
        endcase
        if (r_s1_instr[1:0] != 2'b11) w_ok = 1'b0;
    end

    // Register fields and immediate; illegal words collapse to all-zero with ill set.
    always_comb begin
        w_dec = '0;
        if (w_ok) begin
            w_dec.name = w_name;
            w_dec.fmt  = w_fmt;
            w_dec.cat  = w_cat;
            w_dec.rd   = (w_fmt == FMT_S || w_fmt == FMT_B) ? 5'd0 : r_s1_instr[11:7];
            w_dec.rs1  = (w_fmt == FMT_U || w_fmt == FMT_J) ? 5'd0 : r_s1_instr[19:15];
            w_dec.rs2  = (w_fmt == FMT_R || w_fmt == FMT_S || w_fmt == FMT_B)
                         ? r_s1_instr[24:20] : 5'd0;
            if (w_noregs) begin
                w_dec.rd  = 5'd0;
                w_dec.rs1 = 5'd0;
                w_dec.rs2 = 5'd0;
            end
            case (w_fmt)
                // CSR forms carry the unsigned CSR address in the immediate
                FMT_I:       w_dec.imm = w_csr ? {20'd0, r_s1_instr[31:20]}
                                               : {{20{r_s1_instr[31]}}, r_s1_instr[31:20]};
                FMT_I_SHIFT: w_dec.imm = {27'd0, r_s1_instr[24:20]};
                FMT_S:       w_dec.imm = {{20{r_s1_instr[31]}}, r_s1_instr[31:25], r_s1_instr[11:7]};
                FMT_B:       w_dec.imm = {{19{r_s1_instr[31]}}, r_s1_instr[31], r_s1_instr[7],
                                          r_s1_instr[30:25], r_s1_instr[11:8], 1'b0};
                FMT_U:       w_dec.imm = {r_s1_instr[31:12], 12'd0};
                FMT_J:       w_dec.imm = {{11{r_s1_instr[31]}}, r_s1_instr[31], r_s1_instr[19:12],
                                          r_s1_instr[20], r_s1_instr[30:21], 1'b0};
                default:     w_dec.imm = 32'd0;
            endcase
        end else begin
            w_dec.ill = 1'b1;
        end
    end

    // S1: raw word capture; flush wins over a same-cycle input handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_instr <= 32'd0;
            r_s1_pc    <= 32'd0;
        end else begin
            if (flush)         r_s1_valid <= 1'b0;
            else if (w_s1_adv) r_s1_valid <= bus.in_valid;
            if (w_s1_adv && bus.in_valid && !flush) begin
                r_s1_instr <= bus.in_instr;
                r_s1_pc    <= bus.in_pc;
            end
        end
    end

    // S2: decoded result, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_dec   <= '0;
            r_s2_pc    <= 32'd0;
        end else begin
            if (flush)         r_s2_valid <= 1'b0;
            else if (w_s2_adv) r_s2_valid <= r_s1_valid;
            if (w_s2_adv && r_s1_valid && !flush) begin
                r_s2_dec <= w_dec;
                r_s2_pc  <= r_s1_pc;
            end
        end
    end

    // Output-handshake counters; a handshake coincident with flush still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_cnt <= '0;
            r_ill_cnt <= '0;
        end else if (r_s2_valid && bus.out_ready) begin
            if (r_s2_dec.ill) r_ill_cnt <= r_ill_cnt + CNT_W'(1);
            else              r_dec_cnt <= r_dec_cnt + CNT_W'(1);
        end
    end

    assign bus.out_valid    = r_s2_valid;
    assign bus.out_name     = r_s2_dec.name;
    assign bus.out_format   = r_s2_dec.fmt;
    assign bus.out_category = r_s2_dec.cat;
    assign bus.out_rd       = r_s2_dec.rd;
    assign bus.out_rs1      = r_s2_dec.rs1;
    assign bus.out_rs2      = r_s2_dec.rs2;
    assign bus.out_imm      = r_s2_dec.imm;
    assign bus.out_illegal  = r_s2_dec.ill;
    assign bus.out_pc       = r_s2_pc;
    assign bus.decoded_cnt  = r_dec_cnt;
    assign bus.illegal_cnt  = r_ill_cnt;
endmodule

// File: tb/tb_riscv_instr_decoder.sv
// Scoreboard bench for riscv_instr_decoder: expected decodes are queued on input
// handshake and compared on output handshake.
module tb_riscv_instr_decoder;
    typedef struct {
        int          name;
        int          fmt;
        int          cat;
        int          rd;
        int          rs1;
        int          rs2;
        logic [31:0] imm;
        logic        ill;
        logic [31:0] pc;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;

    riscv_instr_decoder_if #(.CNT_W(32)) bus ();

    riscv_instr_decoder #(.CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int          n_chk   = 0;
    int          n_pass  = 0;
    int          cyc     = 0;
    int          m_dec   = 0;
    int          m_ill   = 0;
    bit          chk_lat = 1'b0;
    bit          last_acc = 1'b0;
    exp_t        cur_exp;
    exp_t        sb[$];
    logic [31:0] pc = 32'h0000_1000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else             n_pass++;
    endtask

    function automatic exp_t mk(int name, int fmt, int cat, int rd, int rs1, int rs2,
                                logic [31:0] imm);
        exp_t e;
        e.name = name; e.fmt = fmt; e.cat = cat;
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.imm = imm; e.ill = 1'b0; e.pc = 32'd0; e.acc = 0;
        return e;
    endfunction

    function automatic exp_t mk_ill();
        exp_t e;
        e = mk(0, 0, 0, 0, 0, 0, 32'd0);
        e.ill = 1'b1;
        return e;
    endfunction

    // Monitor: compare on output handshake, then track flush/input handshake.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            m_dec    = 0;
            m_ill    = 0;
            last_acc = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("name",    32'(bus.out_name),     32'(e.name));
                    chk("format",  32'(bus.out_format),   32'(e.fmt));
                    chk("category",32'(bus.out_category), 32'(e.cat));
                    chk("rd",      32'(bus.out_rd),       32'(e.rd));
                    chk("rs1",     32'(bus.out_rs1),      32'(e.rs1));
                    chk("rs2",     32'(bus.out_rs2),      32'(e.rs2));
                    chk("imm",     bus.out_imm,           e.imm);
                    chk("illegal", 32'(bus.out_illegal),  32'(e.ill));
                    chk("pc",      bus.out_pc,            e.pc);
                    if (chk_lat) chk("latency", 32'(cyc - e.acc), 32'd2);
                    if (e.ill) m_ill++;
                    else       m_dec++;
                end
            end
            if (flush) begin
                sb.delete();
            end else if (bus.in_valid && bus.in_ready) begin
                e     = cur_exp;
                e.acc = cyc;
                sb.push_back(e);
            end
            last_acc = bus.in_valid && bus.in_ready && !flush;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic present(input logic [31:0] w, input exp_t e);
        e.pc         = pc;
        cur_exp      = e;
        bus.in_instr = w;
        bus.in_pc    = pc;
        bus.in_valid = 1'b1;
    endtask

    task automatic wait_acc();
        int k = 0;
        do begin
            step(1);
            k++;
        end while (!last_acc && k < 50);
        if (!last_acc) chk("accept_timeout", 32'(k), 32'd0);
        bus.in_valid = 1'b0;
        pc = pc + 32'd4;
    endtask

    task automatic send(input logic [31:0] w, input exp_t e);
        present(w, e);
        wait_acc();
    endtask

    initial begin : wdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin : main
        logic [5:0]  held_name;
        logic [31:0] held_imm;
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_pc     = 32'd0;
        bus.out_ready = 1'b1;
        #2;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        step(2);
        rst_n = 1'b1;
        chk("rst_name",  32'(bus.out_name), 32'd0);
        chk("rst_imm",   bus.out_imm,       32'd0);
        chk("rst_pc",    bus.out_pc,        32'd0);
        chk("rst_dcnt",  bus.decoded_cnt,   32'd0);
        chk("rst_icnt",  bus.illegal_cnt,   32'd0);
        chk("rst_ready", 32'(bus.in_ready), 32'd1);

        // Basic stream at full throughput
        chk_lat = 1'b1;
        send(32'h0000_0013, mk(37, 2, 3, 0, 0, 0, 32'h0));
        send(32'hFFF0_0093, mk(18, 2, 3, 1, 0, 0, 32'hFFFF_FFFF));
        send(32'h40B5_0533, mk(28, 5, 3, 10, 10, 11, 32'h0));
        step(3);
        chk("dcnt_3", bus.decoded_cnt, 32'd3);

        // Format / immediate coverage
        send(32'hFE20_8EE3, mk(4, 4, 6, 0, 1, 2, 32'hFFFF_FFFC));
        send(32'h1234_52B7, mk(0, 1, 3, 5, 0, 0, 32'h1234_5000));
        send(32'h00A1_2423, mk(17, 6, 1, 0, 2, 10, 32'h8));
        send(32'h4030_D093, mk(26, 3, 2, 1, 1, 0, 32'h3));
        send(32'h0080_00EF, mk(2, 0, 7, 1, 0, 0, 32'h8));
        send(32'h3052_D073, mk(45, 2, 11, 0, 5, 0, 32'h305));
        send(32'h0000_0073, mk(40, 2, 9, 0, 0, 0, 32'h0));
        step(3);
        chk("dcnt_10", bus.decoded_cnt, 32'd10);

        // Illegal words
        send(32'hFFFF_FFFF, mk_ill());
        send(32'h0200_5013, mk_ill());
        step(3);
        chk("icnt_2",       bus.illegal_cnt, 32'd2);
        chk("dcnt_hold_10", bus.decoded_cnt, 32'd10);

        // Back-pressure: two accepted, third held off, then drain in order
        chk_lat       = 1'b0;
        bus.out_ready = 1'b0;
        send(32'h00A1_2423, mk(17, 6, 1, 0, 2, 10, 32'h8));
        send(32'hFFF0_0093, mk(18, 2, 3, 1, 0, 0, 32'hFFFF_FFFF));
        present(32'h40B5_0533, mk(28, 5, 3, 10, 10, 11, 32'h0));
        step(3);
        chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_name",      32'(bus.out_name),  32'd17);
        held_name = bus.out_name;
        held_imm  = bus.out_imm;
        step(2);
        chk("stall_name_hold", 32'(bus.out_name), 32'(held_name));
        chk("stall_imm_hold",  bus.out_imm,       held_imm);
        bus.out_ready = 1'b1;
        wait_acc();
        step(4);
        chk("stall_drained", 32'(sb.size()),  32'd0);
        chk("dcnt_13",       bus.decoded_cnt, 32'd13);

        // Flush with both stages full: S2 word delivered this cycle, rest dropped
        bus.out_ready = 1'b0;
        send(32'h0080_00EF, mk(2, 0, 7, 1, 0, 0, 32'h8));
        send(32'h1234_52B7, mk(0, 1, 3, 5, 0, 0, 32'h1234_5000));
        step(1);
        present(32'hFE20_8EE3, mk(4, 4, 6, 0, 1, 2, 32'hFFFF_FFFC));
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        step(1);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        pc           = pc + 32'd4;
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        step(4);
        chk("flush_idle",  32'(bus.out_valid), 32'd0);
        chk("flush_dcnt",  bus.decoded_cnt,    32'd14);
        chk("flush_icnt",  bus.illegal_cnt,    32'd2);

        // Flush beats a same-cycle input handshake on an empty pipe
        present(32'h0000_0013, mk(37, 2, 3, 0, 0, 0, 32'h0));
        flush = 1'b1;
        step(1);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        step(4);
        chk("flush_in_dropped", 32'(bus.out_valid), 32'd0);
        chk("flush_in_dcnt",    bus.decoded_cnt,    32'd14);

        // Asynchronous reset mid-stream
        chk_lat = 1'b1;
        send(32'hFFF0_0093, mk(18, 2, 3, 1, 0, 0, 32'hFFFF_FFFF));
        send(32'h40B5_0533, mk(28, 5, 3, 10, 10, 11, 32'h0));
        present(32'h0000_0013, mk(37, 2, 3, 0, 0, 0, 32'h0));
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_dcnt",      bus.decoded_cnt,    32'd0);
        chk("arst_icnt",      bus.illegal_cnt,    32'd0);
        chk("arst_in_ready",  32'(bus.in_ready),  32'd1);
        bus.in_valid = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        send(32'h4030_D093, mk(26, 3, 2, 1, 1, 0, 32'h3));
        step(3);
        chk("post_rst_dcnt", bus.decoded_cnt, 32'd1);
        chk("post_rst_sb",   32'(sb.size()),  32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/riscv_instr_decoder.md
# riscv_instr_decoder

Pipelined RV32I instruction decoder for the simprisc bench and core models. It accepts raw 32-bit instruction words with their PC over a valid/ready handshake. Two cycles later it emits the decoded instruction name, format, category, register indices, sign-extended immediate and an illegal flag, all encoded with the ordinals of the shared `riscv_instruction_properties` package. It sits between instruction fetch (or a bench instruction source) and execute/scoreboard consumers, and keeps wrap-around counts of decoded and illegal words.

## Interface
Parameters:
- CNT_W, 32, width of the decoded and illegal counters.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops all in-flight entries.
- in_valid  in  1  in_instr/in_pc are valid.
- in_ready  out  1  decoder can accept this cycle.
- in_instr  in  32  raw instruction word.
- in_pc  in  32  PC of the word.
- out_valid  out  1  decoded result is valid.
- out_ready  in  1  consumer accepts this cycle.
- out_name  out  6  riscv_instr_name_t ordinal (LUI=0 … CSRRCI=47).
- out_format  out  4  riscv_instr_format_t ordinal (J=0, U=1, I=2, I_SHIFT=3, B=4, R=5, S=6).
- out_category  out  4  riscv_instr_cateogry_t ordinal (LOAD=0 … CSR=11).
- out_rd / out_rs1 / out_rs2  out  5 each  register indices.
- out_imm  out  32  decoded immediate.
- out_illegal  out  1  word not a recognised RV32I encoding.
- out_pc  out  32  in_pc carried through.
- decoded_cnt / illegal_cnt  out  CNT_W each  counters.

## Operation
- Structure: stage S1 registers in_instr and in_pc. Stage S2 registers the full decode of S1. The outputs are driven directly from S2 flops.
- Elastic control:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - Full throughput of one word per cycle when not stalled. No bubble is inserted when out_ready is held high.
- Decode by opcode [6:0], funct3 [14:12] and funct7 [31:25]:
  - 0110111 LUI (U, ARITH); 0010111 AUIPC (U, ARITH).
  - 1101111 JAL (J, JUMP); 1100111 with f3=000 JALR (I, JUMP).
  - 1100011 branches (B, BRANCH): f3 000/001/100/101/110/111 → BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - 0000011 loads (I, LOAD): f3 000/001/010/100/101 → LB/LH/LW/LBU/LHU.
  - 0100011 stores (S, STORE): f3 000/001/010 → SB/SH/SW.
  - 0010011 ALU-immediate:
    - ADDI (ARITH); SLTI/SLTIU (COMPARE); XORI/ORI/ANDI (LOGICAL), all format I.
    - SLLI requires f7=0000000. SRLI requires f7=0000000. SRAI requires f7=0100000. All three are I_SHIFT, SHIFT.
    - Exact word 0x00000013 decodes as NOP (I, ARITH), not ADDI.
  - 0110011 R-type (R): f7=0000000 gives ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND; f7=0100000 gives SUB (f3=000) and SRA (f3=101).
    - Categories: ADD/SUB ARITH; SLL/SRL/SRA SHIFT; SLT/SLTU COMPARE; XOR/OR/AND LOGICAL.
  - 0001111: f3=000 FENCE, f3=001 FENCEI (I, SYNCH).
  - 1110011:
    - Exact 0x00000073 is ECALL; exact 0x00100073 is EBREAK (I, SYSTEM).
    - f3 001/010/011/101/110/111 → CSRRW/CSRRS/CSRRC/CSRRWI/CSRRSI/CSRRCI (I, CSR).
- Immediates:
  - I: sext(instr[31:20]). I_SHIFT: zext(instr[24:20]).
  - S: sext({[31:25],[11:7]}). B: sext({[31],[7],[30:25],[11:8],1'b0}).
  - U: {[31:12],12'b0}. J: sext({[31],[19:12],[20],[30:21],1'b0}).
  - CSR: zext(instr[31:20]), the CSR address; for the *I forms, out_rs1 carries zimm = instr[19:15].
- Register fields:
  - Fields the format does not use are driven 0: U/J have no rs1/rs2; I has no rs2; S/B have no rd.
  - FENCE, FENCEI, ECALL and EBREAK drive rd = rs1 = rs2 = 0.
- Illegal: instr[1:0]≠11, unknown opcode, or an unlisted funct3/funct7 combination.
  - out_illegal=1; name, format, category, regs and imm all forced to 0; out_pc still valid.
- Counters:
  - On each output handshake (out_valid & out_ready), decoded_cnt increments if !out_illegal, otherwise illegal_cnt increments.
  - Both wrap modulo 2^CNT_W and are unaffected by flush.

## Timing
- Reset (async assert, sync-to-clk deassert externally): s1_valid = s2_valid = 0 and all datapath flops = 0. Therefore out_valid=0, every out_* field=0, and both counters=0; in_ready=1 during and after reset.
- Latency: a word handshaken in cycle c appears with out_valid=1 in cycle c+2 if no stall.
- Stall: out_valid=1 & out_ready=0 freezes S2. All out_* fields are held stable until accepted.
- When both S1 and S2 are full and stalled, in_ready=0. At most 2 words are in flight.
- flush:
  - Clears s1_valid and s2_valid at the edge and has priority over a same-cycle input handshake; that word is discarded.
  - in_ready is unaffected by flush.
  - A same-cycle output handshake still counts.
- rst_n assertion mid-stream discards all in-flight words immediately, with no completion.

## Test plan
- Reset, then stream 0x00000013, 0xFFF00093, 0x40B50533 with out_ready=1 → results in cycles 2, 3, 4:
  - NOP(37)/fmt 2/cat 3.
  - ADDI(18) rd=1 rs1=0 imm=0xFFFFFFFF.
  - SUB(28) fmt 5 rd=10 rs1=10 rs2=11; decoded_cnt=3.
- 0xFE208EE3 → BEQ(4) fmt 4 rs1=1 rs2=2 rd=0 imm=0xFFFFFFFC.
- 0xFFFFFFFF, then 0x02005013 (f7 illegal for SRLI) → both out_illegal=1 with all fields 0; illegal_cnt=2, decoded_cnt unchanged.
- Hold out_ready=0 while sending 3 words → in_ready drops after 2 accepted; outputs stay stable. Release → all 3 delivered in order, no loss or duplication.
- Fill both stages, pulse flush with in_valid=1 → next cycle out_valid=0; the flushed words never appear; counters unchanged.
- Assert rst_n=0 asynchronously mid-stream → out_valid and counters go to 0 before the next clock edge.
